// File: rtl/fuzzy_sched.sv
// Round-robin scheduler that feeds one station's clamped rain/soil sample at a time to an
// external fuzzy risk engine, waits for its result (with timeout) and reports it.
module fuzzy_sched #(
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned ALARM_TH = 170
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] rain_in,
    input  logic [31:0] soil_in,
    output logic [3:0]  grant,
    output logic        eng_en,
    output logic [7:0]  eng_rain,
    output logic [7:0]  eng_soil,
    input  logic [7:0]  eng_risk,
    input  logic        eng_done,
    output logic        res_valid,
    output logic [1:0]  res_id,
    output logic [7:0]  res_risk,
    output logic        res_alarm,
    output logic        err_timeout,
    output logic [7:0]  timeout_cnt
);

    // Wide enough to count up to TIMEOUT without wrapping.
    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StGrant, StWait, StResult} state_e;

    state_e state_q, state_d;

    logic [3:0]      grant_q, grant_d;
    logic            eng_en_q, eng_en_d;
    logic [7:0]      eng_rain_q, eng_rain_d;
    logic [7:0]      eng_soil_q, eng_soil_d;
    logic            res_valid_q, res_valid_d;
    logic [1:0]      res_id_q, res_id_d;
    logic [7:0]      res_risk_q, res_risk_d;
    logic            res_alarm_q, res_alarm_d;
    logic            err_timeout_q, err_timeout_d;
    logic [7:0]      timeout_cnt_q, timeout_cnt_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      win_q, win_d;

    logic            rr_found;
    logic [1:0]      rr_win;
    logic            wait_expired;

    function automatic logic [7:0] clamp100(input logic [7:0] v);
        return (v > 8'd100) ? 8'd100 : v;
    endfunction

    // Last WAIT cycle before timeout; eng_done sampled in it still wins.
    assign wait_expired = (wait_cnt_q == CntW'(TIMEOUT - 1));

    // Round-robin search starting one past the last winner.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && req[ptr_q + 2'(k)]) begin
                rr_found = 1'b1;
                rr_win   = ptr_q + 2'(k);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (rr_found) state_d = StGrant;
            StGrant:  state_d = StWait;
            StWait:   if (eng_done || wait_expired) state_d = StResult;
            StResult: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        grant_d       = 4'd0;
        eng_en_d      = 1'b0;
        eng_rain_d    = eng_rain_q;
        eng_soil_d    = eng_soil_q;
        res_valid_d   = 1'b0;
        res_id_d      = res_id_q;
        res_risk_d    = res_risk_q;
        res_alarm_d   = res_alarm_q;
        err_timeout_d = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_d    = 4'b0001 << rr_win;
                    eng_rain_d = clamp100(rain_in[{rr_win, 3'b000} +: 8]);
                    eng_soil_d = clamp100(soil_in[{rr_win, 3'b000} +: 8]);
                    ptr_d      = rr_win;
                    win_d      = rr_win;
                end
            end
            StGrant: begin
                eng_en_d   = 1'b1;
                wait_cnt_d = '0;
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (eng_done) begin
                    res_valid_d = 1'b1;
                    res_id_d    = win_q;
                    res_risk_d  = eng_risk;
                    res_alarm_d = ({24'd0, eng_risk} >= ALARM_TH);
                end else if (wait_expired) begin
                    res_valid_d   = 1'b1;
                    res_id_d      = win_q;
                    res_risk_d    = 8'd0;
                    res_alarm_d   = (ALARM_TH == 0);
                    err_timeout_d = 1'b1;
                    if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
                end else begin
                    eng_en_d = 1'b1;
                end
            end
            StResult: begin
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q       <= 4'd0;
            eng_en_q      <= 1'b0;
            eng_rain_q    <= 8'd0;
            eng_soil_q    <= 8'd0;
            res_valid_q   <= 1'b0;
            res_id_q      <= 2'd0;
            res_risk_q    <= 8'd0;
            res_alarm_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            timeout_cnt_q <= 8'd0;
            wait_cnt_q    <= '0;
            ptr_q         <= 2'd3;
            win_q         <= 2'd0;
        end else begin
            grant_q       <= grant_d;
            eng_en_q      <= eng_en_d;
            eng_rain_q    <= eng_rain_d;
            eng_soil_q    <= eng_soil_d;
            res_valid_q   <= res_valid_d;
            res_id_q      <= res_id_d;
            res_risk_q    <= res_risk_d;
            res_alarm_q   <= res_alarm_d;
            err_timeout_q <= err_timeout_d;
            timeout_cnt_q <= timeout_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
        end
    end

    assign grant       = grant_q;
    assign eng_en      = eng_en_q;
    assign eng_rain    = eng_rain_q;
    assign eng_soil    = eng_soil_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_risk    = res_risk_q;
    assign res_alarm   = res_alarm_q;
    assign err_timeout = err_timeout_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: doc/fuzzy_sched.md
FUZZY_SCHED -- requirements
Module: fuzzy_sched

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles spent in WAIT for eng_done.
REQ-002 Parameter ALARM_TH, default 170: res_risk threshold for res_alarm.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  4  per-station level request; bit i = station i holds a valid sample.
REQ-006 rain_in  input  32  packed rainfall; station i at bits [8i+7:8i], unit 0..100.
REQ-007 soil_in  input  32  packed soil moisture; same packing as rain_in.
REQ-008 grant  output  4  one-hot, one-cycle pulse; station i's sample has been captured.
REQ-009 eng_en  output  1  enable to the fuzzy risk engine.
REQ-010 eng_rain  output  8  rainfall operand to the engine.
REQ-011 eng_soil  output  8  soil operand to the engine.
REQ-012 eng_risk  input  8  engine risk result, 0..255.
REQ-013 eng_done  input  1  engine result valid; sampled only in WAIT.
REQ-014 res_valid  output  1  one-cycle pulse; res_* fields valid.
REQ-015 res_id  output  2  station index of the result.
REQ-016 res_risk  output  8  captured risk; 0 on timeout.
REQ-017 res_alarm  output  1  res_risk >= ALARM_TH; qualified by res_valid.
REQ-018 err_timeout  output  1  one-cycle pulse with res_valid when WAIT timed out.
REQ-019 timeout_cnt  output  8  count of timeouts since reset; saturates at 255.

Function
REQ-020 States SHALL be IDLE, GRANT, WAIT, RESULT; all outputs registered.
REQ-021 IDLE: req == 0 -> stay; otherwise pick winner i, latch operands, go to GRANT.
REQ-022 Arbitration SHALL be round-robin: search from (ptr+1) mod 4 upward with wrap; the first set req bit wins; ptr <= winner.
REQ-023 Operand latch SHALL clamp each byte: value > 100 -> 100, else unchanged.
REQ-024 GRANT, one cycle: grant[i] = 1, eng_rain/eng_soil drive the latched operands; next state WAIT, wait counter cleared.
REQ-025 WAIT: eng_en = 1; operands held stable; wait counter +1 per cycle.
REQ-026 WAIT with eng_done = 1: capture eng_risk; go to RESULT. eng_done takes priority over timeout in the same cycle.
REQ-027 WAIT with counter reaching TIMEOUT and no eng_done: res_risk = 0; err_timeout pending; timeout_cnt +1 (saturating); go to RESULT.
REQ-028 RESULT, one cycle: res_valid = 1, res_id = winner, res_risk and res_alarm valid, err_timeout as pending; eng_en = 0; next state IDLE.
REQ-029 eng_en SHALL be 0 outside WAIT; eng_done outside WAIT SHALL be ignored.
REQ-030 req changes outside IDLE SHALL be ignored; a req dropped before being granted is not served.
REQ-031 Latency: req sampled in IDLE at cycle N -> grant at N+1 -> eng_en from N+2 -> res_valid one cycle after the eng_done sample. Minimum res_valid at N+3.
REQ-032 Back-to-back: a station held high is re-granted only after the other requesting stations have been served.
REQ-033 res_id, res_risk and res_alarm SHALL hold their values until the next RESULT.

Reset
REQ-034 rst_n = 0 at a clock edge SHALL, from any state (including mid-WAIT), force IDLE. Effects:
- grant = 0, eng_en = 0, eng_rain = 0, eng_soil = 0
- res_valid = 0, res_id = 0, res_risk = 0, res_alarm = 0
- err_timeout = 0, timeout_cnt = 0, wait counter = 0, ptr = 3
REQ-035 After reset, station 0 SHALL have first priority; an in-flight request is discarded with no res_valid.

Verification
REQ-036 Reset; req = 4'b0001, rain 50, soil 50; eng_done with eng_risk 170 on the 2nd WAIT cycle -> grant = 0001, then res_valid with id 0, risk 170, alarm 1.
REQ-037 req = 4'b1111 held, eng_done on the 1st WAIT cycle each time -> grants 0001, 0010, 0100, 1000, 0001; res_valid every 4 cycles.
REQ-038 rain byte 200, soil byte 101 -> eng_rain = 100, eng_soil = 100 throughout WAIT.
REQ-039 eng_done never asserted -> after 15 WAIT cycles: res_valid, res_risk 0, err_timeout 1, timeout_cnt 1; 256 timeouts -> timeout_cnt stays 255.
REQ-040 rst_n low during WAIT -> next cycle IDLE, eng_en 0, no res_valid; next req = 4'b1010 -> grant 0010.
REQ-041 eng_done and timeout in the same cycle -> eng_risk captured, err_timeout 0, timeout_cnt unchanged; eng_risk 169 -> res_alarm 0.
